// File: rtl/bubble_sort_engine.sv
// Odd-even transposition sorter: one parallel compare-swap phase per enabled cycle,
// with early exit once two consecutive phases make no swaps.
module bubble_sort_engine #(
  parameter int WIDTH = 8,
  parameter int N     = 8,
  localparam int PW   = $clog2(N + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic                 in_valid,
  input  logic                 descend,
  output logic                 in_ready,
  output logic [N*WIDTH-1:0]   out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PW-1:0]        phases
);

  typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_elem [N];
  logic [WIDTH-1:0]   w_next_elem [N];
  logic               r_desc;
  logic               r_odd;
  logic               r_zero_prev;
  logic [PW-1:0]      r_phases;
  logic [PW-1:0]      w_ph_next;
  logic               w_any_swap;
  logic               w_sort_done;

  // Pairs in a phase never overlap, so every swap reads only the registered elements.
  always_comb begin
    w_any_swap = 1'b0;
    for (int i = 0; i < N; i++) w_next_elem[i] = r_elem[i];
    for (int i = 0; i < N - 1; i++) begin
      if (((i % 2) == 1) == r_odd) begin
        if (r_desc ? (r_elem[i] < r_elem[i+1]) : (r_elem[i] > r_elem[i+1])) begin
          w_next_elem[i]   = r_elem[i+1];
          w_next_elem[i+1] = r_elem[i];
          w_any_swap       = 1'b1;
        end
      end
    end
  end

  assign w_ph_next   = r_phases + 1'b1;
  assign w_sort_done = (w_ph_next == PW'(N)) || (!w_any_swap && r_zero_prev);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else if (en) r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: if (in_valid) w_state_next = SORT;
      SORT: if (w_sort_done) w_state_next = DONE;
      DONE: if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) r_elem[i] <= '0;
      r_desc      <= 1'b0;
      r_odd       <= 1'b0;
      r_zero_prev <= 1'b0;
      r_phases    <= '0;
    end else if (en) begin
      case (r_state)
        IDLE: if (in_valid) begin
          for (int i = 0; i < N; i++) r_elem[i] <= in_data[i*WIDTH +: WIDTH];
          r_desc      <= descend;
          r_odd       <= 1'b0;
          r_zero_prev <= 1'b0;
          r_phases    <= '0;
        end
        SORT: begin
          for (int i = 0; i < N; i++) r_elem[i] <= w_next_elem[i];
          r_phases    <= w_ph_next;
          r_odd       <= ~r_odd;
          r_zero_prev <= ~w_any_swap;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) out_data[i*WIDTH +: WIDTH] = r_elem[i];
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign phases    = r_phases;

endmodule

// File: tb/tb_bubble_sort_engine.sv
// Bench for bubble_sort_engine (N=4, WIDTH=8): table of vectors through a
// scoreboard queue, plus hand sequences for backpressure, clock enable and reset abort.
module tb_bubble_sort_engine;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int PW = $clog2(N + 1);

  logic           clk;
  logic           rst;
  logic           en;
  logic [N*W-1:0] in_data;
  logic           in_valid;
  logic           descend;
  logic           in_ready;
  logic [N*W-1:0] out_data;
  logic           out_valid;
  logic           out_ready;
  logic [PW-1:0]  phases;

  int checks   = 0;
  int failures = 0;

  bubble_sort_engine #(.WIDTH(W), .N(N)) dut (
    .clk(clk), .rst(rst), .en(en), .in_data(in_data), .in_valid(in_valid),
    .descend(descend), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .phases(phases)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N*W-1:0] din;
    logic           desc;
    logic [N*W-1:0] dout;
    int             ph;
  } vec_t;

  typedef struct {
    logic [N*W-1:0] dout;
    int             ph;
  } exp_t;

  vec_t tbl[8];
  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [N*W-1:0] d, input logic dsc,
                        input logic [N*W-1:0] eo, input int ph);
    exp_t e;
    int t = 0;
    while (!in_ready && t < 20) begin tick(); t++; end
    check("ready_wait", in_ready, 1);
    in_data  = d;
    descend  = dsc;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    e.dout = eo;
    e.ph   = ph;
    sb.push_back(e);
  endtask

  task automatic drain(input string nm, input int exp_lat);
    exp_t e;
    int lat = 0;
    while (!out_valid && lat < 40) begin tick(); lat++; end
    check({nm, "_latency"}, lat, exp_lat);
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_scoreboard actual=empty expected=entry", nm);
    end else begin
      e = sb.pop_front();
      check({nm, "_data"}, out_data, e.dout);
      check({nm, "_phases"}, phases, e.ph);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({nm, "_idle_ready"}, in_ready, 1);
    check({nm, "_idle_valid"}, out_valid, 0);
  endtask

  initial begin
    // elements packed {e3,e2,e1,e0}
    tbl[0] = '{32'h01020304, 1'b0, 32'h04030201, 4}; // 4,3,2,1 asc
    tbl[1] = '{32'h04030201, 1'b0, 32'h04030201, 2}; // already sorted
    tbl[2] = '{32'h04030201, 1'b1, 32'h01020304, 4}; // 1,2,3,4 desc
    tbl[3] = '{32'h05000505, 1'b0, 32'h05050500, 4}; // 5,5,0,5 asc
    tbl[4] = '{32'h07070707, 1'b0, 32'h07070707, 2}; // all equal
    tbl[5] = '{32'h018000FF, 1'b0, 32'hFF800100, 4}; // unsigned extremes
    tbl[6] = '{32'h04030102, 1'b0, 32'h04030201, 3}; // early exit at 3
    tbl[7] = '{32'h09000000, 1'b1, 32'h00000009, 4}; // 0,0,0,9 desc

    rst = 1'b0; en = 1'b1; in_data = '0; in_valid = 1'b0;
    descend = 1'b0; out_ready = 1'b0;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_phases", phases, 0);
    check("rst_out_data", out_data, 0);
    @(negedge clk);
    rst = 1'b1;

    for (int v = 0; v < 8; v++) begin
      accept(tbl[v].din, tbl[v].desc, tbl[v].dout, tbl[v].ph);
      drain($sformatf("vec%0d", v), tbl[v].ph);
    end

    // Backpressure in DONE with a competing input offered
    accept(32'h01020304, 1'b0, 32'h04030201, 4);
    for (int c = 0; c < 4; c++) tick();
    in_valid = 1'b1;
    in_data  = 32'h11223344;
    for (int c = 0; c < 3; c++) begin
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, 32'h04030201);
      check("hold_phases", phases, 4);
      check("hold_in_ready", in_ready, 0);
      tick();
    end
    in_valid = 1'b0;
    drain("hold", 0);
    tick();
    check("hold_no_accept", in_ready, 1);

    // Clock enable low for 2 cycles after phase 1
    accept(32'h01020304, 1'b0, 32'h04030201, 4);
    tick();
    en = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      check("en_phases", phases, 1);
      check("en_data", out_data, 32'h02010403);
      check("en_valid", out_valid, 0);
    end
    en = 1'b1;
    drain("en", 3);

    // Reset pulse after phase 2 aborts the sort
    accept(32'h01020304, 1'b0, 32'h04030201, 4);
    tick();
    tick();
    check("abort_phases_mid", phases, 2);
    check("abort_data_mid", out_data, 32'h02040103);
    rst = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_phases", phases, 0);
    check("abort_data", out_data, 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("abort_no_present", out_valid, 0);
    accept(tbl[5].din, tbl[5].desc, tbl[5].dout, tbl[5].ph);
    drain("after_abort", tbl[5].ph);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bubble_sort_engine.md
BUBBLE_SORT_ENGINE -- requirements
Module: bubble_sort_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bit width of each element.
REQ-002 SHALL have parameter N, default 8: elements per vector, legal range N>=2.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port en, input, 1 bit: clock enable; when 0, all internal state holds.
REQ-006 SHALL have port in_data, input, N*WIDTH bits: unsorted vector; element i is bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-008 SHALL have port descend, input, 1 bit: sort order, 0 = ascending, 1 = descending; sampled at acceptance.
REQ-009 SHALL have port in_ready, output, 1 bit: engine can accept a vector.
REQ-010 SHALL have port out_data, output, N*WIDTH bits: sorted vector, same element packing as in_data.
REQ-011 SHALL have port out_valid, output, 1 bit: out_data holds a finished result.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-013 SHALL have port phases, output, $clog2(N+1) bits: number of compare-swap phases used for the current or last vector.

Function
REQ-014 SHALL implement FSM states IDLE, SORT and DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-015 SHALL, in IDLE with en=1, in_valid=1 at a rising edge, register in_data, latch descend, clear phases and the phase parity to even, and enter SORT.
REQ-016 SHALL, in SORT, perform one odd-even transposition phase per enabled cycle, with all compare-swaps of the phase done in parallel.
REQ-017 SHALL, in an even phase, compare pairs (0,1),(2,3),...; in an odd phase, compare pairs (1,2),(3,4),...; the parity SHALL alternate every phase.
REQ-018 SHALL compare unsigned; in ascending mode, swap a pair (i,i+1) only if elem[i] > elem[i+1]; in descending mode, only if elem[i] < elem[i+1]. Equal elements are never swapped.
REQ-019 SHALL increment phases by 1 per executed phase.
REQ-020 SHALL leave SORT for DONE at the edge that completes phase N, or earlier at the edge completing a zero-swap phase that immediately follows another zero-swap phase.
REQ-021 SHALL treat an odd phase with no pairs (N=2) as a zero-swap phase.
REQ-022 SHALL raise out_valid exactly k enabled edges after acceptance, where k = final phases value, with 2 <= k <= N.
REQ-023 SHALL, in DONE, hold out_data and phases stable while out_ready=0, and return to IDLE at an enabled edge with out_ready=1.
REQ-024 SHALL ignore in_valid while not in IDLE; no input is lost or overwritten.
REQ-025 SHALL drive out_data directly from the element registers, with no extra output latency.

Reset
REQ-026 SHALL, on rst=0, immediately force IDLE, in_ready=1, out_valid=0, phases=0, element registers=0 and latched descend=0, regardless of clk or en.
REQ-027 SHALL abort an in-progress sort when reset is asserted during SORT or DONE; the aborted vector is discarded and never presented.
REQ-028 SHALL allow acceptance at the first enabled rising edge after rst is deasserted.

Verification
REQ-029 SHALL be verified with N=4, WIDTH=8, ascending, elements 0..3 = 4,3,2,1 -> out 1,2,3,4, phases=4, out_valid 4 edges after accept.
REQ-030 SHALL be verified with already-sorted input 1,2,3,4, ascending -> out 1,2,3,4, phases=2 (early exit).
REQ-031 SHALL be verified with input 1,2,3,4 and descend=1 -> out 4,3,2,1, phases=4; input 5,5,0,5 ascending -> out 0,5,5,5.
REQ-032 SHALL be verified with out_ready held 0 for 3 cycles in DONE -> out_data and phases stable, in_ready=0, new in_valid ignored; release -> IDLE next edge.
REQ-033 SHALL be verified with en=0 for 2 cycles mid-SORT -> elements and phases frozen, result delayed by exactly 2 cycles.
REQ-034 SHALL be verified with rst pulsed low after phase 2 of 4,3,2,1 -> out_valid=0 and in_ready=1 immediately; the next vector sorts correctly.
